reduce: RTL and testbench
=========================

Name: reduce

Overview:
Load-result width reducer for the RV32I pipelined core, sitting in the writeback path after data-memory read. Takes the raw 32-bit word and narrows it to word, halfword or byte, sign- or zero-extended per the load type (LW, LH, LHU, LB, LBU). The datapath output is combinational. A registered sticky error flag records illegal width encodings.

Parameters:
None. All widths are fixed: 32-bit data, 3-bit width select.

Ports:
clk  input  1  system clock; used only by the error flag and the optional output register
reset  input  1  synchronous, active-high reset
BaseResult  input  32  raw loaded word; data is right-aligned, so bits [15:0] and [7:0] are the valid lanes
WidthSrc  input  3  width/extension select; encoding listed in Behaviour
Result  output  32  reduced and extended result
WidthErr  output  1  sticky flag; set when an illegal WidthSrc is presented

Behaviour:
- WidthSrc encoding: bit 2 = unsigned (zero-extend); bits [1:0] select size (00 word, 10 halfword, 01 byte).
- 000 (LW): Result = BaseResult.
- 010 (LH): Result = {16{BaseResult[15]}, BaseResult[15:0]}.
- 110 (LHU): Result = {16'b0, BaseResult[15:0]}.
- 001 (LB): Result = {24{BaseResult[7]}, BaseResult[7:0]}.
- 101 (LBU): Result = {24'b0, BaseResult[7:0]}.
- Illegal codes (011, 100, 111): Result = BaseResult (pass-through). Never X.
- Result latency without the optional feature: purely combinational, zero cycles. Result must be valid within the same timestep as its inputs. Result is unaffected by clk and reset.
- Bits of BaseResult above the selected lane are ignored for halfword and byte sizes.
- WidthErr:
  - Flop; reset value 0.
  - On each rising clk with reset=0, if WidthSrc is an illegal code, WidthErr <= 1. Once set, it stays 1 until reset.
  - Reset has priority when it coincides with an illegal code: WidthErr = 0 after that edge.
  - An illegal code presented during reset does not set the flag.
- Reset mid-operation affects only registered state (WidthErr, and the optional Result register).

Optional Feature:
REDUCE_OUT_REG_EN
- Defined:
  - Result is registered: captured on rising clk, giving 1-cycle latency.
  - Result resets to 32'h0000_0000 synchronously while reset=1.
  - WidthErr timing is unchanged.
- Undefined: Result is combinational, as described in Behaviour. This is the default build used by the core.

Test Plan:
- Word: BaseResult=32'h8765_4321, WidthSrc=000 -> Result=32'h8765_4321.
- Signed halfword:
  - BaseResult=32'h1234_8001, WidthSrc=010 -> Result=32'hFFFF_8001.
  - BaseResult=32'hFFFF_7001, WidthSrc=010 -> Result=32'h0000_7001.
- Unsigned halfword: BaseResult=32'hABCD_8001, WidthSrc=110 -> Result=32'h0000_8001.
- Bytes:
  - BaseResult=32'h1234_5680, WidthSrc=001 -> Result=32'hFFFF_FF80.
  - Same BaseResult, WidthSrc=101 -> Result=32'h0000_0080.
  - BaseResult=32'hFFFF_FF7F, WidthSrc=001 -> Result=32'h0000_007F.
- Illegal code and flag sequence:
  1. Assert reset -> WidthErr=0.
  2. Release reset; apply WidthSrc=011, BaseResult=32'hDEAD_BEEF -> Result=32'hDEAD_BEEF; WidthErr=1 after the next clk edge.
  3. Apply a legal code -> WidthErr stays 1.
  4. Assert reset -> WidthErr=0.

Source files
------------

// File: rtl/reduce.sv
// Load-result width reducer: narrows the loaded word to word/half/byte with sign or zero extension, plus a sticky illegal-width flag.
// Latency 0 (combinational Result), or 1 cycle when REDUCE_OUT_REG_EN is defined; no backpressure.
module reduce (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] BaseResult,
  input  logic [2:0]  WidthSrc,
  output logic [31:0] Result,
  output logic        WidthErr
);

  logic [31:0] result_d;
  logic        illegal;
  logic        width_err_d;
  logic        width_err_q;

  always_comb begin
    result_d = BaseResult;
    illegal  = 1'b0;
    case (WidthSrc)
      3'b000:  result_d = BaseResult;
      3'b010:  result_d = {{16{BaseResult[15]}}, BaseResult[15:0]};
      3'b110:  result_d = {16'h0000, BaseResult[15:0]};
      3'b001:  result_d = {{24{BaseResult[7]}}, BaseResult[7:0]};
      3'b101:  result_d = {24'h000000, BaseResult[7:0]};
      default: begin
        // Illegal codes pass the raw word through so the output is never X.
        result_d = BaseResult;
        illegal  = 1'b1;
      end
    endcase
  end

  always_comb begin
    width_err_d = width_err_q | illegal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      width_err_q <= 1'b0;
    end else begin
      width_err_q <= width_err_d;
    end
  end

  assign WidthErr = width_err_q;

`ifdef REDUCE_OUT_REG_EN
  logic [31:0] result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 32'h0000_0000;
    end else begin
      result_q <= result_d;
    end
  end

  assign Result = result_q;
`else
  assign Result = result_d;
`endif

endmodule

// File: tb/tb_reduce.sv
// Bench for reduce: directed literal pins from the load-type table, then randomized loads against a lane/mask model.
module tb_reduce;

  logic        clk;
  logic        reset;
  logic [31:0] BaseResult;
  logic [2:0]  WidthSrc;
  logic [31:0] Result;
  logic        WidthErr;

  int checks;
  int errors;
  bit check_en;

  logic        exp_err;
  logic [31:0] exp_res_q;

  reduce dut (
    .clk        (clk),
    .reset      (reset),
    .BaseResult (BaseResult),
    .WidthSrc   (WidthSrc),
    .Result     (Result),
    .WidthErr   (WidthErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane width from the size field, mask the lane, then fill the upper bits on signed loads.
  function automatic logic [31:0] ref_reduce(input logic [31:0] b, input logic [2:0] w);
    int          n;
    logic [31:0] mask;
    logic [31:0] v;
    case (w)
      3'b010, 3'b110: n = 16;
      3'b001, 3'b101: n = 8;
      default:        n = 32;
    endcase
    if (n == 32) return b;
    mask = (32'h1 << n) - 32'h1;
    v    = b & mask;
    if (!w[2] && b[n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit is_illegal(input logic [2:0] w);
    return (w == 3'b011) || (w == 3'b100) || (w == 3'b111);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference state updated from the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      exp_err   <= 1'b0;
      exp_res_q <= 32'h0;
    end else begin
      exp_err   <= exp_err | is_illegal(WidthSrc);
      exp_res_q <= ref_reduce(BaseResult, WidthSrc);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_err", {31'b0, WidthErr}, {31'b0, exp_err});
`ifdef REDUCE_OUT_REG_EN
      chk("model_res", Result, exp_res_q);
`else
      chk("model_res", Result, ref_reduce(BaseResult, WidthSrc));
`endif
    end
  end

  task automatic drive(input logic r, input logic [31:0] b, input logic [2:0] w);
    @(posedge clk);
    #2;
    reset      = r;
    BaseResult = b;
    WidthSrc   = w;
  endtask

  task automatic pin(input string name, input logic [31:0] b, input logic [2:0] w,
                     input logic [31:0] exp);
    drive(1'b0, b, w);
`ifdef REDUCE_OUT_REG_EN
    @(posedge clk);
`endif
    @(negedge clk);
    #1;
    chk(name, Result, exp);
    chk({name, "_model"}, ref_reduce(b, w), exp);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    check_en   = 1'b0;
    reset      = 1'b1;
    BaseResult = 32'h0;
    WidthSrc   = 3'b000;
    repeat (2) @(posedge clk);
    #2;
    check_en = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_err", {31'b0, WidthErr}, 32'h0);
`ifdef REDUCE_OUT_REG_EN
    chk("reset_res", Result, 32'h0);
`endif

    pin("lw",       32'h8765_4321, 3'b000, 32'h8765_4321);
    pin("lh_neg",   32'h1234_8001, 3'b010, 32'hFFFF_8001);
    pin("lh_pos",   32'hFFFF_7001, 3'b010, 32'h0000_7001);
    pin("lhu",      32'hABCD_8001, 3'b110, 32'h0000_8001);
    pin("lb_neg",   32'h1234_5680, 3'b001, 32'hFFFF_FF80);
    pin("lbu",      32'h1234_5680, 3'b101, 32'h0000_0080);
    pin("lb_pos",   32'hFFFF_FF7F, 3'b001, 32'h0000_007F);
    chk("err_after_legal", {31'b0, WidthErr}, 32'h0);

    // Illegal code: pass-through now, flag rises only after the next edge.
    drive(1'b0, 32'hDEAD_BEEF, 3'b011);
`ifndef REDUCE_OUT_REG_EN
    #1;
    chk("illegal_pass", Result, 32'hDEAD_BEEF);
`endif
    @(negedge clk);
    #1;
    chk("err_before_edge", {31'b0, WidthErr}, 32'h0);
    drive(1'b0, 32'h0000_1111, 3'b000);
`ifdef REDUCE_OUT_REG_EN
    #1;
    chk("illegal_pass_reg", Result, 32'hDEAD_BEEF);
`endif
    @(negedge clk);
    #1;
    chk("err_set", {31'b0, WidthErr}, 32'h1);
    drive(1'b0, 32'h0000_2222, 3'b010);
    @(negedge clk);
    #1;
    chk("err_sticky", {31'b0, WidthErr}, 32'h1);
    drive(1'b1, 32'h0000_3333, 3'b111);
    @(negedge clk);
    #1;
    chk("err_before_reset_edge", {31'b0, WidthErr}, 32'h1);
    drive(1'b1, 32'h0000_4444, 3'b100);
    @(negedge clk);
    #1;
    chk("err_reset_priority", {31'b0, WidthErr}, 32'h0);
    drive(1'b0, 32'h0000_5555, 3'b000);
    @(negedge clk);
    #1;
    chk("err_not_set_in_reset", {31'b0, WidthErr}, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      logic [2:0] w;
      logic       r;
      r = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 2))
          0:       w = 3'b011;
          1:       w = 3'b100;
          default: w = 3'b111;
        endcase
      end else begin
        case ($urandom_range(0, 4))
          0:       w = 3'b000;
          1:       w = 3'b010;
          2:       w = 3'b110;
          3:       w = 3'b001;
          default: w = 3'b101;
        endcase
      end
      drive(r, $urandom, w);
    end

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
